// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer that shares one single-port synchronous RAM
// between two requesters and returns read data with a one-cycle ack pulse.
module ram_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              gen_reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              busy,
   output logic              grant,
   output logic              ram_write_enable,
   output logic              ram_read_enable,
   output logic [ADDR_W-1:0] ram_adress,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out,
   output logic [1:0]        o_dbg_state
);

   // Handshake: a requester raises reqN with weN/addrN/wdataN and holds them
   // until ackN pulses; reqN still high in the cycle after ackN is a new request.

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT_RD = 2'd2,
      S_ACK     = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                r_grant;
   logic                r_last_grant;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata0;
   logic [DATA_W-1:0]   r_rdata1;
   logic                w_win;
   logic                w_start;

   // On a tie the port not served last wins; a lone requester always wins.
   assign w_win   = (req0 & req1) ? ~r_last_grant : req1;
   assign w_start = (r_state == S_IDLE) & (req0 | req1);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (req0 | req1) w_next = S_ISSUE;
         S_ISSUE:   w_next = r_we ? S_ACK : S_WAIT_RD;
         S_WAIT_RD: w_next = S_ACK;
         S_ACK:     w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (gen_reset) begin
         r_state      <= S_IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata0     <= '0;
         r_rdata1     <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_grant      <= w_win;
            r_last_grant <= w_win;
            r_we         <= w_win ? we1 : we0;
            r_addr       <= w_win ? addr1 : addr0;
            r_wdata      <= w_win ? wdata1 : wdata0;
         end
         // RAM output is valid during the cycle after the read strobe.
         if (r_state == S_WAIT_RD) begin
            if (r_grant) r_rdata1 <= ram_data_out;
            else         r_rdata0 <= ram_data_out;
         end
      end
   end

   assign ram_write_enable = (r_state == S_ISSUE) &  r_we;
   assign ram_read_enable  = (r_state == S_ISSUE) & ~r_we;
   assign ram_adress       = r_addr;
   assign ram_data_in      = r_wdata;

   assign ack0        = (r_state == S_ACK) & ~r_grant;
   assign ack1        = (r_state == S_ACK) &  r_grant;
   assign rdata0      = r_rdata0;
   assign rdata1      = r_rdata1;
   assign busy        = (r_state != S_IDLE);
   assign grant       = r_grant;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: single-port vector table, two-port
// contention/fairness sequences and a reset during an outstanding read.
module tb_ram_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk;
   logic          gen_reset;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, busy, grant;
   logic [DW-1:0] rdata0, rdata1;
   logic          ram_write_enable, ram_read_enable;
   logic [AW-1:0] ram_adress;
   logic [DW-1:0] ram_data_in, ram_data_out;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_rd0, exp_rd1;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .gen_reset(gen_reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .busy(busy), .grant(grant),
      .ram_write_enable(ram_write_enable), .ram_read_enable(ram_read_enable),
      .ram_adress(ram_adress), .ram_data_in(ram_data_in),
      .ram_data_out(ram_data_out), .o_dbg_state(dbg_state)
   );

   // clock / RAM model
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_write_enable) mem[ram_adress] <= ram_data_in;
      if (ram_read_enable)  ram_data_out <= mem[ram_adress];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit            port;
      bit            we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
      string         name;
   } vec_t;

   vec_t vecs[7];

   // one transaction on one port, checked for latency, strobes and data
   task automatic run_single(input vec_t v);
      int  lat, n_we, n_re, n_both, n_bad;
      bit  done;
      lat = 0; n_we = 0; n_re = 0; n_both = 0; n_bad = 0; done = 0;
      @(posedge clk); #1;
      if (v.port == 1'b0) begin
         req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
      end else begin
         req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
      end
      @(posedge clk);
      for (int c = 1; c <= 8 && !done; c++) begin
         @(negedge clk);
         if (ram_write_enable) n_we++;
         if (ram_read_enable) n_re++;
         if (ram_write_enable && ram_read_enable) n_both++;
         if (v.port ? ack0 : ack1) n_bad++;
         if (v.port ? ack1 : ack0) begin
            done = 1;
            lat = c;
            if (!v.we) begin
               if (v.port) exp_rd1 = v.exp_rdata;
               else        exp_rd0 = v.exp_rdata;
            end
            check({v.name, "_grant"}, DW'(grant), DW'(v.port));
            check({v.name, "_busy"}, DW'(busy), 1);
            check({v.name, "_rdata0"}, rdata0, exp_rd0);
            check({v.name, "_rdata1"}, rdata1, exp_rd1);
         end
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      check({v.name, "_ack_latency"}, DW'(lat), v.we ? 2 : 3);
      check({v.name, "_we_pulses"}, DW'(n_we), v.we ? 1 : 0);
      check({v.name, "_re_pulses"}, DW'(n_re), v.we ? 0 : 1);
      check({v.name, "_both_en"}, DW'(n_both), 0);
      check({v.name, "_wrong_ack"}, DW'(n_bad), 0);
   endtask

   // both ports request together; hold=1 keeps them re-requesting
   task automatic run_pair(input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                           input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                           input bit hold, input int n_exp, input bit first,
                           input logic [DW-1:0] er0, input logic [DW-1:0] er1,
                           input string name);
      int  k, n_en, n_both, n_dual;
      bit  drop0, drop1, p;
      k = 0; n_en = 0; n_both = 0; n_dual = 0; drop0 = 0; drop1 = 0;
      @(posedge clk); #1;
      req0 = 1'b1; we0 = wa; addr0 = aa; wdata0 = da;
      req1 = 1'b1; we1 = wb; addr1 = ab; wdata1 = db;
      for (int c = 0; c < 60 && k < n_exp; c++) begin
         @(posedge clk); #1;
         if (drop0) begin req0 = 1'b0; drop0 = 0; end
         if (drop1) begin req1 = 1'b0; drop1 = 0; end
         @(negedge clk);
         if (ram_write_enable || ram_read_enable) n_en++;
         if (ram_write_enable && ram_read_enable) n_both++;
         if (ack0 && ack1) n_dual++;
         if (ack0 || ack1) begin
            p = ack1;
            if (p == 1'b0 && !wa) exp_rd0 = er0;
            if (p == 1'b1 && !wb) exp_rd1 = er1;
            check($sformatf("%s_order%0d", name, k), DW'(p), DW'(first ^ k[0]));
            check($sformatf("%s_grant%0d", name, k), DW'(grant), DW'(p));
            check($sformatf("%s_rdata0_%0d", name, k), rdata0, exp_rd0);
            check($sformatf("%s_rdata1_%0d", name, k), rdata1, exp_rd1);
            if (!hold) begin
               if (p) drop1 = 1;
               else   drop0 = 1;
            end
            k++;
         end
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      check({name, "_ack_count"}, DW'(k), DW'(n_exp));
      check({name, "_en_pulses"}, DW'(n_en), DW'(n_exp));
      check({name, "_both_en"}, DW'(n_both), 0);
      check({name, "_dual_ack"}, DW'(n_dual), 0);
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 10'h011, 32'd15,         32'd0,         "p0_wr_011"};
      vecs[1] = '{1'b0, 1'b0, 10'h011, 32'd0,          32'd15,        "p0_rd_011"};
      vecs[2] = '{1'b1, 1'b1, 10'h3FF, 32'd100,        32'd0,         "p1_wr_3ff"};
      vecs[3] = '{1'b1, 1'b0, 10'h3FF, 32'd0,          32'd100,       "p1_rd_3ff"};
      vecs[4] = '{1'b0, 1'b1, 10'h000, 32'hFFFF_FFFF,  32'd0,         "p0_wr_000"};
      vecs[5] = '{1'b0, 1'b0, 10'h000, 32'd0,          32'hFFFF_FFFF, "p0_rd_000"};
      vecs[6] = '{1'b1, 1'b1, 10'h200, 32'hA5A5_A5A5,  32'd0,         "p1_wr_200"};

      // reset with both ports requesting
      gen_reset = 1'b1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 10'h005; wdata0 = 32'd7;
      req1 = 1'b1; we1 = 1'b1; addr1 = 10'h006; wdata1 = 32'd8;
      exp_rd0 = '0; exp_rd1 = '0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("rst%0d_we", i), DW'(ram_write_enable), 0);
         check($sformatf("rst%0d_re", i), DW'(ram_read_enable), 0);
         check($sformatf("rst%0d_acks", i), DW'({ack1, ack0}), 0);
         check($sformatf("rst%0d_rdata0", i), rdata0, 0);
         check($sformatf("rst%0d_rdata1", i), rdata1, 0);
         check($sformatf("rst%0d_busy", i), DW'(busy), 0);
         check($sformatf("rst%0d_grant", i), DW'(grant), 0);
         check($sformatf("rst%0d_addr", i), DW'(ram_adress), 0);
         check($sformatf("rst%0d_din", i), ram_data_in, 0);
         check($sformatf("rst%0d_state", i), DW'(dbg_state), 0);
      end
      @(posedge clk); #1;
      gen_reset = 1'b0; req0 = 1'b0; req1 = 1'b0;

      run_pair(1'b1, 10'h005, 32'd7, 1'b1, 10'h006, 32'd8, 1'b0, 2, 1'b0, 0, 0, "post_rst");

      foreach (vecs[i]) run_single(vecs[i]);

      run_pair(1'b1, 10'h02C, 32'd25, 1'b1, 10'h041, 32'd35, 1'b0, 2, 1'b0, 0, 0, "contend");
      run_pair(1'b0, 10'h02C, 32'd0, 1'b0, 10'h041, 32'd0, 1'b1, 6, 1'b0, 32'd25, 32'd35, "fair");

      // reset while a port-1 read waits for RAM data
      @(posedge clk); #1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 10'h3FF;
      @(posedge clk);
      @(negedge clk);
      check("mid_issue_state", DW'(dbg_state), 1);
      check("mid_issue_re", DW'(ram_read_enable), 1);
      @(posedge clk); #1;
      gen_reset = 1'b1;
      @(negedge clk);
      check("mid_wait_state", DW'(dbg_state), 2);
      @(posedge clk); #1;
      gen_reset = 1'b0; req1 = 1'b0;
      exp_rd0 = '0; exp_rd1 = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("mid_rst%0d_state", i), DW'(dbg_state), 0);
         check($sformatf("mid_rst%0d_acks", i), DW'({ack1, ack0}), 0);
         check($sformatf("mid_rst%0d_busy", i), DW'(busy), 0);
         check($sformatf("mid_rst%0d_rdata1", i), rdata1, 0);
      end
      run_single('{1'b1, 1'b0, 10'h3FF, 32'd0, 32'd100, "reissue_rd_3ff"});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
